// File: rtl/ws_pkg.sv
// Shared types for the weight-stationary pass scheduler: FSM states, latched layer config
// and the config legality rule.
package ws_pkg;

  localparam int ARRAY_COLS = 14;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALC    = 3'd1,
    LOAD    = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  typedef struct packed {
    logic [8:0]  m;
    logic [8:0]  c;
    logic [3:0]  r;
    logic [3:0]  s;
    logic [3:0]  p;
    logic [3:0]  q;
    logic [11:0] n_cyc;
  } cfg_t;

  // A zero dimension or more filters per pass than PE columns cannot be scheduled.
  function automatic logic cfg_illegal(input cfg_t cfg);
    logic bad;
    bad = (cfg.m == 9'd0) || (cfg.c == 9'd0) || (cfg.r == 4'd0) || (cfg.s == 4'd0) ||
          (cfg.p == 4'd0) || (cfg.q == 4'd0) || (cfg.n_cyc == 12'd0) ||
          ({28'd0, cfg.p} > 32'(ARRAY_COLS));
    return bad;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The first step is folded into the
// start cycle, so done appears DIV_W+1 cycles after start is raised (start cycle included).
module seq_divider #(
  parameter int DIV_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0]   r_rem;
  logic [DIV_W-1:0]   r_quo;
  logic [DIV_W-1:0]   r_dvs;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*DIV_W-1:0] w_step;

  function automatic logic [2*DIV_W-1:0] div_step(input logic [DIV_W-1:0] rem,
                                                  input logic [DIV_W-1:0] quo,
                                                  input logic [DIV_W-1:0] dvs);
    logic [DIV_W:0]   trial;
    logic [DIV_W-1:0] rem_n;
    logic             bit_n;
    trial = {rem, quo[DIV_W-1]};
    if (trial >= {1'b0, dvs}) begin
      rem_n = DIV_W'(trial - {1'b0, dvs});
      bit_n = 1'b1;
    end else begin
      rem_n = DIV_W'(trial);
      bit_n = 1'b0;
    end
    return {rem_n, quo[DIV_W-2:0], bit_n};
  endfunction

  // A new start always restarts from the fresh operands.
  always_comb begin
    w_step = '0;
    if (start) begin
      w_step = div_step('0, dividend, divisor);
    end else begin
      w_step = div_step(r_rem, r_quo, r_dvs);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem  <= w_step[2*DIV_W-1:DIV_W];
        r_quo  <= w_step[DIV_W-1:0];
        r_dvs  <= divisor;
        r_cnt  <= CNT_W'(DIV_W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_step[2*DIV_W-1:DIV_W];
        r_quo <= w_step[DIV_W-1:0];
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done     = r_done;
  assign quotient = r_quo;

endmodule

// File: rtl/ws_pass_scheduler.sv
// Sequences one weight-stationary conv layer as filter-group (outer) x channel-group (inner)
// passes, each pass being LOAD -> COMPUTE -> DRAIN over the PE array.
module ws_pass_scheduler
  import ws_pkg::*;
#(
  parameter int DRAIN_LAT = 14,
  parameter int DIV_W     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [8:0]  M,
  input  logic [8:0]  C,
  input  logic [3:0]  R,
  input  logic [3:0]  S,
  input  logic [3:0]  P,
  input  logic [3:0]  Q,
  input  logic [11:0] n_cyc,
  input  logic        ifmap_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        fb_rst,
  output logic        fb_en,
  output logic        ifmap_en,
  output logic        psum_acc,
  output logic        ofmap_wr,
  output logic [8:0]  m_grp,
  output logic [8:0]  c_grp
);

  localparam int OP_LEN   = DIV_W + 1;
  localparam int CALC_LEN = 3 * OP_LEN;
  localparam int CW       = $clog2(CALC_LEN);
  localparam logic [CW-1:0] OP1_LAST  = CW'(OP_LEN - 1);
  localparam logic [CW-1:0] OP2_FIRST = CW'(OP_LEN);
  localparam logic [CW-1:0] OP2_LAST  = CW'(2 * OP_LEN - 1);
  localparam logic [CW-1:0] OP3_FIRST = CW'(2 * OP_LEN);
  localparam logic [CW-1:0] CALC_PRE  = CW'(CALC_LEN - 2);
  localparam logic [CW-1:0] CALC_LAST = CW'(CALC_LEN - 1);
  localparam logic [11:0]   DRAIN_LAST = 12'(DRAIN_LAT - 1);

  state_e           r_state;
  cfg_t             r_cfg;
  cfg_t             w_cfg_in;
  logic [CW-1:0]    r_calc_cnt;
  logic [11:0]      r_cnt;
  logic [DIV_W-1:0] r_cip;
  logic [DIV_W-1:0] r_nc;
  logic [DIV_W-1:0] r_nm;
  logic [8:0]       r_m;
  logic [8:0]       r_c;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_fb_rst;
  logic             r_fb_en;
  logic             r_psum_acc;
  logic             r_ofmap_wr;

  logic             w_div_start;
  logic             w_div_done;
  logic [DIV_W-1:0] w_dvd;
  logic [DIV_W-1:0] w_dvs;
  logic [DIV_W-1:0] w_quo;
  logic [7:0]       w_fs;
  logic             w_last_c;
  logic             w_last_m;

  assign w_cfg_in = '{m: M, c: C, r: R, s: S, p: P, q: Q, n_cyc: n_cyc};
  assign w_fs     = {4'd0, r_cfg.r} * {4'd0, r_cfg.s};
  assign w_last_c = (DIV_W'(r_c) == (r_nc - DIV_W'(1)));
  assign w_last_m = (DIV_W'(r_m) == (r_nm - DIV_W'(1)));

  // Three back-to-back divides in CALC: cip = Q/fs, n_c = ceil(C/cip), n_m = ceil(M/P).
  assign w_div_start = (r_state == CALC) && !r_err && !abort &&
                       ((r_calc_cnt == '0) || (r_calc_cnt == OP2_FIRST) || (r_calc_cnt == OP3_FIRST));

  // Operand mux selected by which third of CALC we are in.
  always_comb begin
    w_dvd = DIV_W'(0);
    w_dvs = DIV_W'(1);
    if (r_calc_cnt < OP2_FIRST) begin
      w_dvd = DIV_W'(r_cfg.q);
      w_dvs = DIV_W'(w_fs);
    end else if (r_calc_cnt < OP3_FIRST) begin
      w_dvd = DIV_W'(r_cfg.c) + r_cip - DIV_W'(1);
      w_dvs = r_cip;
    end else begin
      w_dvd = DIV_W'(r_cfg.m) + DIV_W'(r_cfg.p) - DIV_W'(1);
      w_dvs = DIV_W'(r_cfg.p);
    end
  end

  seq_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_div_start),
    .dividend (w_dvd),
    .divisor  (w_dvs),
    .done     (w_div_done),
    .quotient (w_quo)
  );

  // Layer FSM with registered strobes; abort outranks every transition outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cfg      <= '0;
      r_calc_cnt <= '0;
      r_cnt      <= 12'd0;
      r_cip      <= '0;
      r_nc       <= '0;
      r_nm       <= '0;
      r_m        <= 9'd0;
      r_c        <= 9'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_fb_rst   <= 1'b0;
      r_fb_en    <= 1'b0;
      r_psum_acc <= 1'b0;
      r_ofmap_wr <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_fb_rst <= 1'b0;
      if ((r_state != IDLE) && abort) begin
        r_state    <= IDLE;
        r_busy     <= 1'b0;
        r_fb_en    <= 1'b0;
        r_psum_acc <= 1'b0;
        r_ofmap_wr <= 1'b0;
        r_m        <= 9'd0;
        r_c        <= 9'd0;
        r_cnt      <= 12'd0;
        r_calc_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_cfg      <= w_cfg_in;
              r_state    <= CALC;
              r_busy     <= 1'b1;
              r_calc_cnt <= '0;
              r_err      <= cfg_illegal(w_cfg_in);
            end
          end
          CALC: begin
            if (r_err) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_calc_cnt <= r_calc_cnt + CW'(1);
              if (w_div_done && (r_calc_cnt == OP1_LAST)) begin
                r_cip <= (w_fs > 8'(r_cfg.q)) ? DIV_W'(1) : w_quo;
              end
              if (w_div_done && (r_calc_cnt == OP2_LAST)) begin
                r_nc <= w_quo;
              end
              if (w_div_done && (r_calc_cnt == CALC_LAST)) begin
                r_nm <= w_quo;
              end
              if (r_calc_cnt == CALC_PRE) begin
                r_fb_rst <= 1'b1;
              end
              if (r_calc_cnt == CALC_LAST) begin
                r_state    <= LOAD;
                r_calc_cnt <= '0;
                r_fb_en    <= 1'b1;
                r_cnt      <= 12'd0;
                r_m        <= 9'd0;
                r_c        <= 9'd0;
                r_psum_acc <= 1'b0;
              end
            end
          end
          LOAD: begin
            if (r_cnt == (12'(r_cfg.q) - 12'd1)) begin
              r_state <= COMPUTE;
              r_fb_en <= 1'b0;
              r_cnt   <= 12'd0;
            end else begin
              r_cnt <= r_cnt + 12'd1;
            end
          end
          COMPUTE: begin
            if (ifmap_valid) begin
              if (r_cnt == (r_cfg.n_cyc - 12'd1)) begin
                r_state    <= DRAIN;
                r_cnt      <= 12'd0;
                r_ofmap_wr <= w_last_c;
              end else begin
                r_cnt <= r_cnt + 12'd1;
              end
            end
          end
          DRAIN: begin
            if (r_cnt == DRAIN_LAST) begin
              r_cnt      <= 12'd0;
              r_ofmap_wr <= 1'b0;
              if (!w_last_c) begin
                r_c        <= r_c + 9'd1;
                r_state    <= LOAD;
                r_fb_en    <= 1'b1;
                r_psum_acc <= 1'b1;
              end else if (!w_last_m) begin
                r_c        <= 9'd0;
                r_m        <= r_m + 9'd1;
                r_state    <= LOAD;
                r_fb_en    <= 1'b1;
                r_psum_acc <= 1'b0;
              end else begin
                r_c        <= 9'd0;
                r_m        <= 9'd0;
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_psum_acc <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + 12'd1;
            end
          end
          default: begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_fb_en    <= 1'b0;
            r_psum_acc <= 1'b0;
            r_ofmap_wr <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign fb_rst   = r_fb_rst;
  assign fb_en    = r_fb_en;
  assign ifmap_en = (r_state == COMPUTE) && ifmap_valid && !abort;
  assign psum_acc = r_psum_acc;
  assign ofmap_wr = r_ofmap_wr;
  assign m_grp    = r_m;
  assign c_grp    = r_c;

endmodule

// File: tb/tb_ws_pass_scheduler.sv
// Directed and randomized layers checked against a pass-list / cycle-count model of the scheduler.
module tb_ws_pass_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, ifmap_valid;
  logic [8:0]  M, C;
  logic [3:0]  R, S, P, Q;
  logic [11:0] n_cyc;
  logic        busy, done, err, fb_rst, fb_en, ifmap_en, psum_acc, ofmap_wr;
  logic [8:0]  m_grp, c_grp;

  int n_cmp = 0;
  int n_bad = 0;
  int k;
  int vmode;
  bit vtab [8192];
  int pm [512], pc [512], pfb [512], pif [512], pacc [512], pwr [512];

  always #5 clk = ~clk;

  ws_pass_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .M(M), .C(C), .R(R), .S(S), .P(P), .Q(Q), .n_cyc(n_cyc),
    .ifmap_valid(ifmap_valid), .busy(busy), .done(done), .err(err),
    .fb_rst(fb_rst), .fb_en(fb_en), .ifmap_en(ifmap_en), .psum_acc(psum_acc),
    .ofmap_wr(ofmap_wr), .m_grp(m_grp), .c_grp(c_grp)
  );

  function automatic bit pat(input int kk);
    if (vmode == 0) return 1'b1;
    else if (vmode == 1) return (kk % 2) == 1;
    else return vtab[kk % 8192];
  endfunction

  function automatic logic [31:0] outs();
    return {6'd0, busy, done, err, fb_rst, fb_en, ifmap_en, psum_acc, ofmap_wr, m_grp, c_grp};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    ifmap_valid = pat(k);
    #1;
  endtask

  task automatic launch(input int m, c, r, s, p, q, nc);
    M = 9'(m); C = 9'(c); R = 4'(r); S = 4'(s); P = 4'(p); Q = 4'(q); n_cyc = 12'(nc);
    start = 1'b1;
    k = -1;
    tick();
    start = 1'b0;
    M = 9'($urandom); C = 9'($urandom); R = 4'($urandom); S = 4'($urandom);
    P = 4'($urandom); Q = 4'($urandom); n_cyc = 12'($urandom);
  endtask

  // ab: 0 = run to done, 1 = abort during second COMPUTE, 2 = abort on the final DRAIN cycle
  task automatic run_layer(input string tag, input int m, c, r, s, p, q, nc, mode, ab);
    int fs, cip, n_c, n_m, np, t, beats, t_cmp1, t_abort, pidx, done_at, fbrst_n, fbrst_at, errs, nd;
    bit prev_fb, fin;
    vmode = mode;
    fs  = r * s;
    cip = (fs > q) ? 1 : q / fs;
    n_c = (c + cip - 1) / cip;
    n_m = (m + p - 1) / p;
    np  = n_m * n_c;
    t = 33;
    t_cmp1 = -1;
    for (int i = 0; i < np; i++) begin
      t += q;
      if (i == 1) t_cmp1 = t;
      beats = 0;
      while (beats < nc) begin
        if (pat(t)) beats++;
        t++;
      end
      t += 14;
    end
    t_abort = (ab == 1) ? t_cmp1 + 2 : (ab == 2) ? t - 1 : -1;
    for (int i = 0; i < 512; i++) begin
      pm[i] = 0; pc[i] = 0; pfb[i] = 0; pif[i] = 0; pacc[i] = 0; pwr[i] = 0;
    end
    pidx = -1; prev_fb = 1'b0; done_at = -1; fbrst_n = 0; fbrst_at = -1; errs = 0; fin = 1'b0;
    launch(m, c, r, s, p, q, nc);
    while (!fin) begin
      if (fb_rst) begin fbrst_n++; fbrst_at = k; end
      if (err) errs++;
      if (fb_en && !prev_fb && pidx < 511) begin
        pidx++;
        pm[pidx] = m_grp;
        pc[pidx] = c_grp;
      end
      prev_fb = fb_en;
      if (pidx >= 0) begin
        if (fb_en) pfb[pidx]++;
        if (ifmap_en) begin
          pif[pidx]++;
          if (psum_acc) pacc[pidx]++;
        end
        if (ofmap_wr) pwr[pidx]++;
      end
      if (done) begin
        done_at = k;
        fin = 1'b1;
      end else if (k == t_abort) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        fin = 1'b1;
      end else if (k >= t + 50) begin
        fin = 1'b1;
      end else begin
        if (k == 50) begin
          start = 1'b1;
          M = 9'd1; C = 9'd1; R = 4'd1; S = 4'd1; P = 4'd1; Q = 4'd1; n_cyc = 12'd1;
        end
        tick();
        start = 1'b0;
      end
    end
    if (ab == 0) begin
      check({tag, "_done_cycle"}, done_at, t);
      check({tag, "_idle_at_done"}, {busy, m_grp, c_grp}, 32'd0);
      check({tag, "_err"}, errs, 0);
      check({tag, "_passes"}, pidx + 1, np);
      check({tag, "_fb_rst_n"}, fbrst_n, 1);
      check({tag, "_fb_rst_at"}, fbrst_at, 32);
      for (int i = 0; i < np && i < 512; i++) begin
        check($sformatf("%s_p%0d_m", tag, i), pm[i], i / n_c);
        check($sformatf("%s_p%0d_c", tag, i), pc[i], i % n_c);
        check($sformatf("%s_p%0d_fb", tag, i), pfb[i], q);
        check($sformatf("%s_p%0d_if", tag, i), pif[i], nc);
        check($sformatf("%s_p%0d_acc", tag, i), pacc[i], ((i % n_c) != 0) ? nc : 0);
        check($sformatf("%s_p%0d_wr", tag, i), pwr[i], ((i % n_c) == n_c - 1) ? 14 : 0);
      end
      tick();
      check({tag, "_done_pulse"}, done, 1'b0);
    end else begin
      check({tag, "_abort_outs"}, outs(), 32'd0);
      check({tag, "_abort_nodone"}, done_at, -1);
      nd = 0;
      repeat (20) begin
        if (done || busy) nd++;
        tick();
      end
      check({tag, "_abort_quiet"}, nd, 0);
    end
  endtask

  task automatic run_err(input string tag, input int m, c, r, s, p, q, nc);
    int cnt;
    vmode = 0;
    launch(m, c, r, s, p, q, nc);
    check({tag, "_err_pulse"}, {err, busy, fb_en, done}, 32'b1100);
    tick();
    check({tag, "_err_clear"}, {err, busy}, 32'd0);
    cnt = 0;
    repeat (30) begin
      if (fb_en || done || err || busy) cnt++;
      tick();
    end
    check({tag, "_err_quiet"}, cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ifmap_valid = 1'b0;
    M = 9'd0; C = 9'd0; R = 4'd0; S = 4'd0; P = 4'd0; Q = 4'd0; n_cyc = 12'd0;
    vmode = 0; k = 0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outs", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", outs(), 32'd0);

    run_layer("t1", 8, 3, 3, 3, 4, 9, 16, 0, 0);
    run_layer("t2", 6, 5, 2, 2, 3, 8, 4, 0, 0);
    run_layer("t3", 8, 3, 3, 3, 4, 9, 16, 1, 0);
    run_err("p15", 8, 3, 3, 3, 15, 9, 16);
    run_err("q0", 8, 3, 3, 3, 4, 0, 16);
    run_err("m0", 0, 3, 3, 3, 4, 9, 16);
    run_layer("ab_cmp", 8, 3, 3, 3, 4, 9, 16, 0, 1);
    run_layer("after_ab", 8, 3, 3, 3, 4, 9, 16, 0, 0);
    run_layer("ab_last", 8, 3, 3, 3, 4, 9, 16, 0, 2);
    run_layer("fs_gt_q", 5, 7, 3, 3, 2, 4, 3, 0, 0);
    run_layer("p14", 20, 4, 1, 1, 14, 1, 2, 0, 0);

    for (int i = 0; i < 8192; i++) vtab[i] = ($urandom_range(0, 3) != 0);
    for (int j = 0; j < 4; j++) begin
      run_layer($sformatf("rnd%0d", j), $urandom_range(1, 12), $urandom_range(1, 12),
                $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 14),
                $urandom_range(1, 15), $urandom_range(1, 10), 2, 0);
    end

    vmode = 0;
    launch(8, 3, 3, 3, 4, 9, 16);
    repeat (37) tick();
    check("pre_rst_load", {busy, fb_en}, 32'b11);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", outs(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
